// File: rtl/mac_pe_v2.sv
// Systolic MAC processing element: forwards operands, accumulates per tile, drains results down a chain.
// Latency: operand forward 1 cycle; own tile result visible on res_vld_out 2 cycles after its last beat.
// Backpressure: res_rdy_in stalls the output register; own result beats upstream; one held result, overflow sets err.
module mac_pe_v2 #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 24,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             sgn,
    input  logic [IN_W-1:0]  a_in,
    input  logic [IN_W-1:0]  b_in,
    input  logic             vld_in,
    input  logic             last_in,
    output logic [IN_W-1:0]  a_out,
    output logic [IN_W-1:0]  b_out,
    output logic             vld_out,
    output logic             last_out,
    input  logic [OUT_W-1:0] res_in,
    input  logic             res_vld_in,
    output logic             res_rdy_out,
    output logic [OUT_W-1:0] res_out,
    output logic             res_vld_out,
    input  logic             res_rdy_in,
    output logic             err
);

    localparam int PROD_W = 2 * IN_W;

    // Signed OUT_W limits expressed in ACC_W bits, plus the unsigned OUT_W ceiling.
    localparam logic [ACC_W-1:0] S_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] S_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] U_MAX = ACC_W'({OUT_W{1'b1}});

    // Accumulator limits for the two modes.
    localparam logic [ACC_W-1:0] ACC_S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_S_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] ACC_U_MAX = {ACC_W{1'b1}};

    logic [ACC_W-1:0]  acc;
    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;
    logic [PROD_W-1:0] prod;
    logic [ACC_W:0]    prod_wide;
    logic [ACC_W:0]    acc_wide;
    logic [ACC_W:0]    sum_wide;
    logic [ACC_W-1:0]  acc_next;

    logic signed [ACC_W-1:0] acc_next_s;
    logic [ACC_W-1:0]  shifted;
    logic [OUT_W-1:0]  tile_res;

    logic [OUT_W-1:0]  hold;
    logic              own_pend;
    logic              beat_last;
    logic              free;
    logic              drain_own;

    // Operand extension to 2*IN_W: the low 2*IN_W bits of the product of the
    // extended operands equal the true signed or unsigned product.
    always_comb begin
        a_ext = sgn ? {{IN_W{a_in[IN_W-1]}}, a_in} : {{IN_W{1'b0}}, a_in};
        b_ext = sgn ? {{IN_W{b_in[IN_W-1]}}, b_in} : {{IN_W{1'b0}}, b_in};
        prod  = a_ext * b_ext;
    end

    // Accumulate in ACC_W+1 bits so both signed overflow and unsigned carry are visible.
    always_comb begin
        prod_wide = sgn ? {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod}
                        : {{(ACC_W+1-PROD_W){1'b0}}, prod};
        acc_wide  = sgn ? {acc[ACC_W-1], acc} : {1'b0, acc};
        sum_wide  = acc_wide + prod_wide;
        acc_next  = sum_wide[ACC_W-1:0];
        if (sgn) begin
            if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
                acc_next = sum_wide[ACC_W] ? ACC_S_MIN : ACC_S_MAX;
            end
        end else begin
            // Products are non-negative in unsigned mode, so only a carry can occur.
            if (sum_wide[ACC_W]) begin
                acc_next = ACC_U_MAX;
            end
        end
    end

    // Tile result: scale by SHIFT, then clamp into the OUT_W range of the mode.
    always_comb begin
        acc_next_s = $signed(acc_next);
        shifted    = sgn ? ACC_W'(acc_next_s >>> SHIFT) : (acc_next >> SHIFT);
        tile_res   = shifted[OUT_W-1:0];
        if (sgn) begin
            if ($signed(shifted) > $signed(S_MAX)) begin
                tile_res = S_MAX[OUT_W-1:0];
            end else if ($signed(shifted) < $signed(S_MIN)) begin
                tile_res = S_MIN[OUT_W-1:0];
            end
        end else begin
            if (shifted > U_MAX) begin
                tile_res = U_MAX[OUT_W-1:0];
            end
        end
    end

    // Drain handshake terms shared by the holding register and output register.
    always_comb begin
        beat_last   = vld_in && last_in;
        free        = !res_vld_out || res_rdy_in;
        drain_own   = free && own_pend;
        res_rdy_out = free && !own_pend;
    end

    // Operand/control forwarding to the neighbour, unconditionally one cycle late.
    always_ff @(posedge clk) begin
        if (clear) begin
            a_out    <= '0;
            b_out    <= '0;
            vld_out  <= 1'b0;
            last_out <= 1'b0;
        end else begin
            a_out    <= a_in;
            b_out    <= b_in;
            vld_out  <= vld_in;
            last_out <= last_in;
        end
    end

    // Accumulator: add on valid beats, restart from zero after the last beat of a tile.
    always_ff @(posedge clk) begin
        if (clear) begin
            acc <= '0;
        end else if (vld_in) begin
            acc <= last_in ? '0 : acc_next;
        end
    end

    // Own-result holding register. A second result arriving while the first
    // cannot leave this cycle is dropped and flagged; if the held one leaves
    // in the same cycle, the new one simply takes its place.
    always_ff @(posedge clk) begin
        if (clear) begin
            hold     <= '0;
            own_pend <= 1'b0;
            err      <= 1'b0;
        end else if (beat_last && own_pend && !drain_own) begin
            err <= 1'b1;
        end else if (beat_last) begin
            hold     <= tile_res;
            own_pend <= 1'b1;
        end else if (drain_own) begin
            own_pend <= 1'b0;
        end
    end

    // Output register: when free, take own result first, else upstream, else go empty.
    always_ff @(posedge clk) begin
        if (clear) begin
            res_out     <= '0;
            res_vld_out <= 1'b0;
        end else if (free) begin
            if (own_pend) begin
                res_out     <= hold;
                res_vld_out <= 1'b1;
            end else if (res_vld_in) begin
                res_out     <= res_in;
                res_vld_out <= 1'b1;
            end else begin
                res_vld_out <= 1'b0;
            end
        end
    end

endmodule
